// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads the word-addressed ROM, fills IF/ID; one-cycle fetch latency.
// Stall holds PC and IF/ID; redirect overrides stall and flushes; stops on HALT word or out-of-range fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] count_q, count_d;
  logic        in_range;
  logic [31:0] pc_plus4;

  assign in_range = (pc_q[31:2] < IMEM_LIMIT);
  assign pc_plus4 = pc_q + 32'd4;

  // Priority: redirect, then stall, then the state's own action.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    fetch_err_d  = fetch_err_q;
    count_d      = count_q;

    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (!in_range) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
            fetch_err_d  = 1'b1;
            state_d      = ST_HALT;
          end else if (imem_dout == HALT_INSTR) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
            state_d      = ST_HALT;
          end else begin
            ifid_instr_d = imem_dout;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
            count_d      = count_q + 32'd1;
          end
        end
        ST_HALT: begin
          ifid_instr_d = NOP_INSTR;
          ifid_pc4_d   = 32'd0;
          ifid_valid_d = 1'b0;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_err_q  <= fetch_err_d;
      count_q      <= count_d;
    end
  end

  assign imem_adr    = {2'b00, pc_q[31:2]};
  assign pc          = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_err   = fetch_err_q;
  assign fetch_count = count_q;

endmodule
